// File: rtl/recv_img.sv
// UART (8N1) receiver that writes each received byte as one pixel into an image BRAM.
// Framing errors are counted (saturating) and never advance the write pointer.
module recv_img #(
  parameter int CLOCKS_PER_BAUD = 50,
  parameter int NUM_PIXELS      = 16384,
  parameter int ADDR_WIDTH      = 14
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rx,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [7:0]            pixel,
  output logic                  we,
  output logic                  busy,
  output logic                  full_image_received,
  output logic                  frame_err,
  output logic [7:0]            err_count,
  output logic [2:0]            out_state
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CNT_W-1:0]      HALF_M1 = CNT_W'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [CNT_W-1:0]      FULL_M1 = CNT_W'(CLOCKS_PER_BAUD - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t                state, state_nx;
  logic                  rx_m, rx_s;
  logic [CNT_W-1:0]      cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shreg;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic                  cnt_clr, shift_en, byte_ok, byte_bad;

  assign out_state = state;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    byte_ok  = 1'b0;
    byte_bad = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nx = START;
          cnt_clr  = 1'b1;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_clr  = 1'b1;
          state_nx = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            byte_ok  = 1'b1;
            state_nx = IDLE;
          end else begin
            byte_bad = 1'b1;
            state_nx = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Counter free-runs in IDLE/BREAK; it is always cleared before it is compared.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (state != DATA) bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;
      if (shift_en) shreg <= {rx_s, shreg[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr              <= '0;
      address             <= '0;
      pixel               <= '0;
      we                  <= 1'b0;
      busy                <= 1'b0;
      full_image_received <= 1'b0;
      frame_err           <= 1'b0;
      err_count           <= '0;
    end else begin
      we                  <= byte_ok;
      frame_err           <= byte_bad;
      full_image_received <= 1'b0;
      if (byte_bad && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (byte_ok) begin
        address <= wr_ptr;
        pixel   <= shreg;
        if (wr_ptr == LAST) begin
          wr_ptr              <= '0;
          busy                <= 1'b0;
          full_image_received <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
          busy   <= 1'b1;
        end
      end
    end
  end

endmodule
